mux_nto1_reg: RTL and testbench

Parametrised, registered N-to-1 word multiplexer. It is the successor to the fixed 8:1 32-bit combinational mux in the datapath.
- One output register stage with a valid/ready handshake, so the selector can sit between pipeline stages.
- Optional SCAN mode: an internal pointer steps through the inputs one accepted transfer at a time. This is used to drain register banks or result slots in order.

---
 rtl/mux_nto1_reg.sv | 87 ++++++++
 tb/tb_mux_nto1_reg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_reg.sv
// mux_nto1_reg: registered N-to-1 word mux with valid/ready output stage and SCAN pointer.
// Define MUX_NTO1_PARITY_EN to add a registered even-parity output (out_parity).
module mux_nto1_reg #(
    parameter int WIDTH = 32,
    parameter int N = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    sel,
    input  logic               scan_mode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    scan_ptr,
`ifdef MUX_NTO1_PARITY_EN
    output logic               out_parity,
`endif
    output logic               scan_wrap
);
    logic             accept;
    logic             last;
    logic [SELW-1:0]  idx;
    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  scan_ptr_q, scan_ptr_d;
    logic             scan_wrap_q, scan_wrap_d;
`ifdef MUX_NTO1_PARITY_EN
    logic             out_parity_q, out_parity_d;
`endif

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign idx      = scan_mode ? scan_ptr_q : sel;
    assign last     = scan_ptr_q == SELW'(N - 1);

    // Channel decode; indices with no matching channel yield zero.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < N; k++)
            if (idx == SELW'(k)) sel_word = in_data[k*WIDTH +: WIDTH];
    end

    // Next state: load on accept, clear valid on drain, advance pointer on scan accepts.
    always_comb begin
        out_data_d  = accept ? sel_word : out_data_q;
        out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        scan_ptr_d  = (accept && scan_mode) ? (last ? '0 : scan_ptr_q + SELW'(1)) : scan_ptr_q;
        scan_wrap_d = accept && scan_mode && last;
`ifdef MUX_NTO1_PARITY_EN
        out_parity_d = accept ? ^sel_word : out_parity_q;
`endif
    end

    // Output register stage with synchronous reset discarding any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            scan_ptr_q  <= '0;
            scan_wrap_q <= 1'b0;
`ifdef MUX_NTO1_PARITY_EN
            out_parity_q <= 1'b0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            scan_ptr_q  <= scan_ptr_d;
            scan_wrap_q <= scan_wrap_d;
`ifdef MUX_NTO1_PARITY_EN
            out_parity_q <= out_parity_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign scan_ptr  = scan_ptr_q;
    assign scan_wrap = scan_wrap_q;
`ifdef MUX_NTO1_PARITY_EN
    assign out_parity = out_parity_q;
`endif
endmodule

// File: tb/tb_mux_nto1_reg.sv
// tb_mux_nto1_reg: directed and randomized checks of mux_nto1_reg (N=8/W=32 and N=6/W=16) against a behavioural model.
module tb_mux_nto1_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, out_ready, scan_mode, run;
    logic [2:0]   sel;
    logic [255:0] da;
    logic [95:0]  db;
    logic         a_ready, a_valid, a_wrap, b_ready, b_valid, b_wrap;
    logic [31:0]  a_data;
    logic [15:0]  b_data;
    logic [2:0]   a_ptr, b_ptr;
`ifdef MUX_NTO1_PARITY_EN
    logic         a_par, b_par;
`endif
    int total = 0;
    int bad = 0;

    mux_nto1_reg #(.WIDTH(32), .N(8)) dut_a (
        .clk(clk), .reset(reset), .in_data(da), .sel(sel), .scan_mode(scan_mode),
        .in_valid(in_valid), .in_ready(a_ready), .out_data(a_data), .out_valid(a_valid),
        .out_ready(out_ready), .scan_ptr(a_ptr),
`ifdef MUX_NTO1_PARITY_EN
        .out_parity(a_par),
`endif
        .scan_wrap(a_wrap));

    mux_nto1_reg #(.WIDTH(16), .N(6)) dut_b (
        .clk(clk), .reset(reset), .in_data(db), .sel(sel), .scan_mode(scan_mode),
        .in_valid(in_valid), .in_ready(b_ready), .out_data(b_data), .out_valid(b_valid),
        .out_ready(out_ready), .scan_ptr(b_ptr),
`ifdef MUX_NTO1_PARITY_EN
        .out_parity(b_par),
`endif
        .scan_wrap(b_wrap));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [255:0] d, input int i, input int w, input int n);
        logic [255:0] m;
        m = (256'd1 << w) - 256'd1;
        return (i >= n) ? 32'd0 : 32'((d >> (i * w)) & m);
    endfunction

    // Behavioural model state: valid, data, pointer, wrap pulse
    logic        ma_v, mb_v, ma_w, mb_w;
    logic [31:0] ma_q, mb_q;
    int          ma_p, mb_p;

    task automatic step(input int n, input int w, input logic [255:0] d,
                        inout logic v, inout logic [31:0] q, inout int p, inout logic wr);
        logic acc;
        acc = in_valid && (!v || out_ready);
        wr = 1'b0;
        if (reset) begin
            v = 1'b0; q = 32'd0; p = 0;
        end else begin
            if (acc) begin
                q = pick(d, scan_mode ? p : int'(sel), w, n);
                if (scan_mode) begin
                    wr = (p == n - 1);
                    p = (p + 1) % n;
                end
            end
            v = acc || (v && !out_ready);
        end
    endtask

    always @(posedge clk) begin
        step(8, 32, da, ma_v, ma_q, ma_p, ma_w);
        step(6, 16, {160'd0, db}, mb_v, mb_q, mb_p, mb_w);
    end

    always @(negedge clk) if (run) begin
        chk("a_valid", 32'(a_valid), 32'(ma_v));
        chk("a_data", a_data, ma_q);
        chk("a_ready", 32'(a_ready), 32'(!ma_v || out_ready));
        chk("a_ptr", 32'(a_ptr), 32'(ma_p));
        chk("a_wrap", 32'(a_wrap), 32'(ma_w));
        chk("b_valid", 32'(b_valid), 32'(mb_v));
        chk("b_data", 32'(b_data), mb_q);
        chk("b_ready", 32'(b_ready), 32'(!mb_v || out_ready));
        chk("b_ptr", 32'(b_ptr), 32'(mb_p));
        chk("b_wrap", 32'(b_wrap), 32'(mb_w));
`ifdef MUX_NTO1_PARITY_EN
        chk("a_par", 32'(a_par), 32'(^ma_q));
        chk("b_par", 32'(b_par), 32'(^mb_q));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int wraps;
        ma_v = 0; mb_v = 0; ma_q = 0; mb_q = 0; ma_p = 0; mb_p = 0; ma_w = 0; mb_w = 0;
        run = 0; reset = 1; in_valid = 0; out_ready = 0; scan_mode = 0; sel = 0;
        for (int k = 0; k < 8; k++) da[k*32 +: 32] = 32'hA000_0000 + k;
        for (int k = 0; k < 6; k++) db[k*16 +: 16] = 16'hB000 + 16'(k);
        cyc(); cyc();
        reset = 0; run = 1;
        smp();
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_data", a_data, 32'd0);
        // manual select
        sel = 5; in_valid = 1; out_ready = 1;
        cyc(); smp();
        chk("t1_valid", 32'(a_valid), 32'd1);
        chk("t1_data", a_data, 32'hA000_0005);
        chk("t1_bdata", 32'(b_data), 32'hB005);
        // back-to-back
        for (int i = 0; i < 4; i++) begin
            sel = 3'(i);
            cyc(); smp();
            chk("b2b_data", a_data, 32'hA000_0000 + i);
            chk("b2b_ready", 32'(a_ready), 32'd1);
        end
        // stall
        sel = 2;
        cyc();
        out_ready = 0; sel = 6;
        for (int i = 0; i < 3; i++) begin
            cyc(); smp();
            chk("stall_ready", 32'(a_ready), 32'd0);
            chk("stall_data", a_data, 32'hA000_0002);
        end
        out_ready = 1;
        cyc(); smp();
        chk("unstall_data", a_data, 32'hA000_0006);
        chk("unstall_valid", 32'(a_valid), 32'd1);
        in_valid = 0;
        cyc(); smp();
        chk("drain_valid", 32'(a_valid), 32'd0);
        chk("drain_hold", a_data, 32'hA000_0006);
        // scan
        scan_mode = 1; in_valid = 1; wraps = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(); smp();
            chk("scan_data", a_data, 32'hA000_0000 + (i % 8));
            chk("scan_wrap", 32'(a_wrap), 32'(i == 7));
            wraps += int'(a_wrap);
        end
        chk("scan_wraps", 32'(wraps), 32'd1);
        in_valid = 0;
        cyc(); smp();
        chk("scan_ptr_a", 32'(a_ptr), 32'd2);
        chk("scan_ptr_b", 32'(b_ptr), 32'd4);
        // out-of-range on N=6, parity, reset while full
        scan_mode = 0; sel = 7; in_valid = 1;
        cyc(); smp();
        chk("oor_data", 32'(b_data), 32'd0);
        chk("oor_valid", 32'(b_valid), 32'd1);
`ifdef MUX_NTO1_PARITY_EN
        chk("par7", 32'(a_par), 32'd1);
`endif
        sel = 3;
        cyc(); smp();
`ifdef MUX_NTO1_PARITY_EN
        chk("par3", 32'(a_par), 32'd0);
`endif
        out_ready = 0;
        cyc();
        reset = 1;
        cyc(); smp();
        chk("rst2_valid", 32'(b_valid), 32'd0);
        chk("rst2_data", 32'(b_data), 32'd0);
        chk("rst2_ptr", 32'(b_ptr), 32'd0);
        reset = 0;
        // randomized
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(99) == 0);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            sel       = 3'($urandom);
            if ($urandom_range(15) == 0) scan_mode = ~scan_mode;
            for (int k = 0; k < 8; k++) da[k*32 +: 32] = $urandom;
            for (int k = 0; k < 6; k++) db[k*16 +: 16] = 16'($urandom);
            cyc();
        end
        smp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
